urp_pcie_rr_arbiter: RTL

Parametrised N-to-1 round-robin arbiter for PCIe TLP streams. It sits between the per-function TLP sources and the shared transmit path. It replaces the fixed two-master, clock-divided arbiter with a true valid/ready handshake on every port and packet-granular locking on `last`. It also adds a registered output stage and an optional stall watchdog.

---
 rtl/urp_pcie_arb_pkg.sv | 16 +
 rtl/urp_pcie_rr_pick.sv | 24 ++
 rtl/urp_pcie_rr_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/urp_pcie_arb_pkg.sv
// rtl/urp_pcie_arb_pkg.sv - shared state type, default constants and pointer helper for the TLP arbiter
package urp_pcie_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int DEFAULT_DATA_SIZE = 224;
    localparam int DEFAULT_TIMEOUT   = 255;

    function automatic int rr_next(input int ptr, input int n);
        return (ptr >= n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/urp_pcie_rr_pick.sv
// rtl/urp_pcie_rr_pick.sv - first valid index at or after the round-robin pointer, with wrap
module urp_pcie_rr_pick #(
    parameter int N_MASTER = 4
) (
    input  logic [N_MASTER-1:0]         valid,
    input  logic [$clog2(N_MASTER)-1:0] rr_ptr,
    output logic [$clog2(N_MASTER)-1:0] idx,
    output logic                        any_valid
);

    localparam int IW = $clog2(N_MASTER);

    always_comb begin
        idx       = '0;
        any_valid = 1'b0;
        for (int off = 0; off < N_MASTER; off++) begin
            if (!any_valid && valid[(int'(rr_ptr) + off) % N_MASTER]) begin
                any_valid = 1'b1;
                idx       = IW'((int'(rr_ptr) + off) % N_MASTER);
            end
        end
    end

endmodule

// File: rtl/urp_pcie_rr_arbiter.sv
// rtl/urp_pcie_rr_arbiter.sv - N-to-1 packet-locked round-robin TLP arbiter with registered output
// Optional stall watchdog enabled by defining URP_PCIE_ARB_TIMEOUT_EN.
module urp_pcie_rr_arbiter
    import urp_pcie_arb_pkg::*;
#(
    parameter int N_MASTER  = 4,
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_MASTER-1:0]           src_valid_i,
    output logic [N_MASTER-1:0]           src_ready_o,
    input  logic [N_MASTER*DATA_SIZE-1:0] src_data_i,
    input  logic [N_MASTER-1:0]           src_last_i,
    output logic                          dst_valid_o,
    input  logic                          dst_ready_i,
    output logic [DATA_SIZE-1:0]          dst_data_o,
    output logic                          dst_last_o,
    output logic [$clog2(N_MASTER)-1:0]   grant_o,
    output logic                          err_timeout_o
);

    localparam int IW = $clog2(N_MASTER);

    arb_state_t           state_q, state_d;
    logic [IW-1:0]        grant_q, grant_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                 dst_valid_q, dst_valid_d;
    logic [DATA_SIZE-1:0] dst_data_q, dst_data_d;
    logic                 dst_last_q, dst_last_d;
    logic                 grant_ready;
    logic                 xfer;
    logic                 wd_fire;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;

    urp_pcie_rr_pick #(
        .N_MASTER (N_MASTER)
    ) u_pick (
        .valid     (src_valid_i),
        .rr_ptr    (rr_ptr_q),
        .idx       (pick_idx),
        .any_valid (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            dst_valid_q <= 1'b0;
            dst_data_q  <= '0;
            dst_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            dst_valid_q <= dst_valid_d;
            dst_data_q  <= dst_data_d;
            dst_last_q  <= dst_last_d;
        end
    end

    // Ready depends only on registered state and dst_ready_i, never on src_valid_i.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        dst_valid_d = dst_valid_q;
        dst_data_d  = dst_data_q;
        dst_last_d  = dst_last_q;
        src_ready_o = '0;
        grant_ready = 1'b0;
        xfer        = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                grant_ready          = !dst_valid_q || dst_ready_i;
                src_ready_o[grant_q] = grant_ready;
                xfer                 = src_valid_i[grant_q] && grant_ready;
                if ((xfer && src_last_i[grant_q]) || wd_fire) begin
                    state_d  = IDLE;
                    rr_ptr_d = IW'(rr_next(int'(grant_q), N_MASTER));
                end
            end
            default: state_d = IDLE;
        endcase

        if (xfer) begin
            dst_valid_d = 1'b1;
            dst_data_d  = src_data_i[int'(grant_q)*DATA_SIZE +: DATA_SIZE];
            dst_last_d  = src_last_i[grant_q];
        end else if (dst_ready_i) begin
            dst_valid_d = 1'b0;
        end
    end

`ifdef URP_PCIE_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt_q;
    logic          err_q;

    // Fires on the TIMEOUT-th idle cycle of the owner; the truncated packet is not closed with last.
    assign wd_fire = (state_q == LOCKED) && !src_valid_i[grant_q] &&
                     (wd_cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= wd_fire;
            if ((state_q != LOCKED) || xfer || wd_fire) begin
                wd_cnt_q <= '0;
            end else if (!src_valid_i[grant_q]) begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
            end
        end
    end

    assign err_timeout_o = err_q;
`else
    assign wd_fire       = 1'b0;
    assign err_timeout_o = 1'b0;
`endif

    assign dst_valid_o = dst_valid_q;
    assign dst_data_o  = dst_data_q;
    assign dst_last_o  = dst_last_q;
    assign grant_o     = grant_q;

endmodule
